// File: rtl/sipo_pkg.sv
// Shared types and defaults for the SIPO load controller and its bit counter.
package sipo_pkg;

  localparam int unsigned SIPO_SIZE = 256;
  localparam int unsigned CNT_W     = $clog2(SIPO_SIZE + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FILL  = 2'd2,
    ST_FULL  = 2'd3
  } sipo_state_e;

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit counter for the SIPO loader: synchronous load-zero, increment, and flags at
// SIZE-1 (next transfer completes the word) and SIZE (word complete).
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int unsigned SIZE = SIPO_SIZE,
  parameter int unsigned W    = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         last_o,
  output logic         tc_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tc_o    = (count_q == W'(SIZE));
  assign last_o  = (count_q == W'(SIZE - 1));
  assign count_o = count_q;

  // Saturates at SIZE so a stray increment can never wrap the count.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !tc_o) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sipo_load_controller.sv
// Loads SIZE serial bits into an external SIPO register via clear/shift commands.
// Optional FILL idle timeout is built only when SIPO_LOAD_CONTROLLER_TIMEOUT_EN is defined.
module sipo_load_controller
  import sipo_pkg::*;
#(
  parameter int unsigned SIZE    = SIPO_SIZE,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      s_valid,
  input  logic                      s_bit,
  output logic                      s_ready,
  output logic                      sr_clear,
  output logic                      sr_shift,
  output logic                      sr_s_in,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic [$clog2(SIZE+1)-1:0] bit_count,
  output logic                      timeout,
  output sipo_state_e               dbg_state
);

  localparam int unsigned CW = $clog2(SIZE + 1);

  sipo_state_e state_q;
  sipo_state_e state_d;
  logic        transfer;
  logic        cnt_clr;
  logic        cnt_last;
  logic        cnt_tc;
  logic        idle_expired;

  assign dbg_state = state_q;
  assign sr_s_in   = s_bit;

  sipo_bit_counter #(
    .SIZE (SIZE),
    .W    (CW)
  ) u_bit_counter (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (cnt_clr),
    .inc_i   (transfer),
    .count_o (bit_count),
    .last_o  (cnt_last),
    .tc_o    (cnt_tc)
  );

`ifdef SIPO_LOAD_CONTROLLER_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] idle_q;
  logic [IW-1:0] idle_d;

  // Abort outranks the timeout, so an aborting cycle never reports expiry.
  assign idle_expired = (state_q == ST_FILL) && !abort && !s_valid &&
                        (idle_q == IW'(TIMEOUT - 1));
  assign timeout      = idle_expired;

  always_comb begin
    idle_d = '0;
    if ((state_q == ST_FILL) && !s_valid && !abort && !idle_expired) begin
      idle_d = idle_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign idle_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_FILL;
      ST_FILL: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (transfer && cnt_last) begin
          state_d = ST_FULL;
        end else if (idle_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (word_ready) begin
          state_d = start ? ST_CLEAR : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Valid/ready: a bit moves exactly in a cycle where s_valid && s_ready; s_ready is
  // high only in FILL without abort and without a completed word, so sr_clear and
  // sr_shift can never coincide.
  always_comb begin
    s_ready    = 1'b0;
    sr_clear   = 1'b0;
    word_valid = 1'b0;
    cnt_clr    = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        sr_clear = 1'b1;
        cnt_clr  = 1'b1;
      end
      ST_FILL: begin
        s_ready = !abort && !cnt_tc;
        cnt_clr = abort || idle_expired;
      end
      ST_FULL:  word_valid = 1'b1;
      default:  ;
    endcase
    transfer = s_ready && s_valid;
    sr_shift = transfer;
  end

endmodule
